// File: rtl/shift_reg_univ.sv
// ---------------------------------------------------------------------------
// shift_reg_univ
//
// Parametrised universal shift register. It holds, shifts up, shifts down or
// loads in parallel, and it provides parallel readout plus a saturating shift
// counter with a one-cycle frame-done pulse. Depending on how the modes are
// used it works as SISO, SIPO, PISO or PIPO.
//
// All state updates on the FALLING edge of CLK. RES is synchronous and
// active-high, and it is also sampled on the falling edge.
//
// Optional feature: define SHIFT_ROTATE_EN to add the 'rot' input. With
// rot=1 a shift feeds the bit being shifted out back in at the other end,
// which turns the shift into a rotation. si is ignored in that case.
//
// Parameters:
//   WIDTH       number of stages, 2..32
//   CW          counter width, $clog2(WIDTH+1) (derived)
//
// Ports:
//   CLK         clock, falling-edge active
//   RES         synchronous active-high reset
//   ce          clock enable; 0 holds all state
//   mode        00 hold, 01 shift up, 10 shift down, 11 parallel load
//   si          serial data in
//   rot         rotate instead of taking si (only with SHIFT_ROTATE_EN)
//   pd          parallel load data
//   q           register contents
//   so_up       serial out for shift up   (q[WIDTH-1])
//   so_dn       serial out for shift down (q[0])
//   shift_cnt   shifts since last load/reset, saturates at WIDTH
//   frame_done  one-cycle pulse on the shift that brings shift_cnt to WIDTH
// ---------------------------------------------------------------------------
module shift_reg_univ #(
   parameter int WIDTH = 4
) (
   input  logic                           CLK,
   input  logic                           RES,
   input  logic                           ce,
   input  logic [1:0]                     mode,
   input  logic                           si,
`ifdef SHIFT_ROTATE_EN
   input  logic                           rot,
`endif
   input  logic [WIDTH-1:0]               pd,
   output logic [WIDTH-1:0]               q,
   output logic                           so_up,
   output logic                           so_dn,
   output logic [$clog2(WIDTH+1)-1:0]     shift_cnt,
   output logic                           frame_done
);

   localparam int CW = $clog2(WIDTH+1);
   localparam logic [CW-1:0] CNT_MAX  = CW'(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      MODE_HOLD = 2'b00,
      MODE_UP   = 2'b01,
      MODE_DN   = 2'b10,
      MODE_LOAD = 2'b11
   } mode_e;

   mode_e            mode_s;
   logic [WIDTH-1:0] q_q, q_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             fd_q, fd_d;
   logic             up_in, dn_in;   // bit entering at q[0] / q[WIDTH-1]
   logic [CW-1:0]    cnt_inc;

   assign mode_s = mode_e'(mode);

   // Incoming serial bit per direction. With rotation enabled the bit
   // leaving at the far end comes back in instead of si.
`ifdef SHIFT_ROTATE_EN
   assign up_in = rot ? q_q[WIDTH-1] : si;
   assign dn_in = rot ? q_q[0]       : si;
`else
   assign up_in = si;
   assign dn_in = si;
`endif

   // Counter saturates at WIDTH so later shifts in the same frame do not wrap.
   assign cnt_inc = (cnt_q < CNT_MAX) ? cnt_q + CW'(1) : cnt_q;

   always_comb begin
      // NOTE: every always_comb output gets a default first so that no path
      // leaves it unassigned, which would otherwise infer a latch.
      q_d   = q_q;
      cnt_d = cnt_q;
      fd_d  = fd_q;
      if (ce) begin
         case (mode_s)
            MODE_HOLD: begin
               fd_d = 1'b0;
            end
            MODE_UP: begin
               q_d   = {q_q[WIDTH-2:0], up_in};
               cnt_d = cnt_inc;
               fd_d  = (cnt_q == CNT_LAST);
            end
            MODE_DN: begin
               q_d   = {dn_in, q_q[WIDTH-1:1]};
               cnt_d = cnt_inc;
               fd_d  = (cnt_q == CNT_LAST);
            end
            MODE_LOAD: begin
               q_d   = pd;
               cnt_d = '0;
               fd_d  = 1'b0;
            end
            default: begin
               q_d   = q_q;
            end
         endcase
      end
   end

   // Falling-edge register bank; reset takes priority over ce and mode.
   always_ff @(negedge CLK) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge values and ordering between blocks cannot race.
      if (RES) begin
         q_q   <= '0;
         cnt_q <= '0;
         fd_q  <= 1'b0;
      end else begin
         q_q   <= q_d;
         cnt_q <= cnt_d;
         fd_q  <= fd_d;
      end
   end

   assign q          = q_q;
   assign so_up      = q_q[WIDTH-1];
   assign so_dn      = q_q[0];
   assign shift_cnt  = cnt_q;
   assign frame_done = fd_q;

endmodule

// File: tb/tb_shift_reg_univ.sv
// ---------------------------------------------------------------------------
// Self-checking bench for shift_reg_univ (WIDTH=4).
//
// A behavioural model treats the register as an integer. A shift is
// multiply/divide by two, and the frame counter is a plain int. One compare
// process checks every DUT output against the model at each rising edge,
// which is the inactive edge. Directed sequences with hand-computed literal
// values pin the model. A randomized phase follows them.
// ---------------------------------------------------------------------------
module tb_shift_reg_univ;

   localparam int W  = 4;
   localparam int CW = $clog2(W+1);
   localparam int MODN = 1 << W;

   logic          CLK = 1'b0;
   logic          RES = 1'b0;
   logic          ce  = 1'b0;
   logic [1:0]    mode = 2'b00;
   logic          si  = 1'b0;
   logic [W-1:0]  pd  = '0;
`ifdef SHIFT_ROTATE_EN
   logic          rot = 1'b0;
`endif
   logic [W-1:0]  q;
   logic          so_up, so_dn;
   logic [CW-1:0] shift_cnt;
   logic          frame_done;

   int total = 0;
   int bad   = 0;

   always #5 CLK = ~CLK;

   shift_reg_univ #(.WIDTH(W)) dut (
      .CLK        (CLK),
      .RES        (RES),
      .ce         (ce),
      .mode       (mode),
      .si         (si),
`ifdef SHIFT_ROTATE_EN
      .rot        (rot),
`endif
      .pd         (pd),
      .q          (q),
      .so_up      (so_up),
      .so_dn      (so_dn),
      .shift_cnt  (shift_cnt),
      .frame_done (frame_done)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int m_q   = 0;
   int m_cnt = 0;
   int m_fd  = 0;
   bit m_valid = 1'b0;

   always @(negedge CLK) begin : model
      int b_in;
      if (RES === 1'b1) begin
         m_q = 0; m_cnt = 0; m_fd = 0; m_valid = 1'b1;
      end else if (m_valid && ce === 1'b1) begin
         b_in = int'(si);
         case (mode)
            2'b00: m_fd = 0;
            2'b01: begin
`ifdef SHIFT_ROTATE_EN
               if (rot) b_in = m_q / (MODN / 2);
`endif
               m_q   = (m_q * 2 + b_in) % MODN;
               m_fd  = (m_cnt + 1 == W) ? 1 : 0;
               m_cnt = (m_cnt + 1 > W) ? W : m_cnt + 1;
            end
            2'b10: begin
`ifdef SHIFT_ROTATE_EN
               if (rot) b_in = m_q % 2;
`endif
               m_q   = m_q / 2 + b_in * (MODN / 2);
               m_fd  = (m_cnt + 1 == W) ? 1 : 0;
               m_cnt = (m_cnt + 1 > W) ? W : m_cnt + 1;
            end
            default: begin
               m_q = int'(pd); m_cnt = 0; m_fd = 0;
            end
         endcase
      end
   end

   // ---------------- compare process ----------------
   always @(posedge CLK) begin
      if (m_valid) begin
         check("q",          32'(q),          32'(m_q));
         check("so_up",      32'(so_up),      32'(m_q / (MODN / 2)));
         check("so_dn",      32'(so_dn),      32'(m_q % 2));
         check("shift_cnt",  32'(shift_cnt),  32'(m_cnt));
         check("frame_done", 32'(frame_done), 32'(m_fd));
      end
   end

   // One falling edge: drive after the rising edge, return just after the
   // falling edge so directed checks see settled outputs.
   task automatic tick(input logic r, input logic c, input logic [1:0] m,
                       input logic s, input logic [W-1:0] p);
      @(posedge CLK);
      RES = r; ce = c; mode = m; si = s; pd = p;
      @(negedge CLK);
      #1;
   endtask

   localparam logic [1:0] HOLD = 2'b00, UP = 2'b01, DN = 2'b10, LD = 2'b11;

   initial begin
      logic [3:0] exp_so;
      logic [3:0] sin;

      // Reset wins over a simultaneous load.
      tick(1, 1, LD, 0, 4'hF);
      check("rst_q",   32'(q), 0);
      check("rst_cnt", 32'(shift_cnt), 0);
      check("rst_fd",  32'(frame_done), 0);

      // PISO: load 1011, shift up 4 with si=0.
      exp_so = 4'b1101;   // so_up expected before edges 0..3 is 1,0,1,1 (LSB first)
      tick(0, 1, LD, 0, 4'b1011);
      for (int i = 0; i < 4; i++) begin
         check("piso_so_up", 32'(so_up), 32'(exp_so[i]));
         tick(0, 1, UP, 0, '0);
         check("piso_fd", 32'(frame_done), (i == 3) ? 1 : 0);
      end
      check("piso_q",   32'(q), 0);
      check("piso_cnt", 32'(shift_cnt), 4);
      // Saturation: a fifth shift leaves the count at 4 and gives no pulse.
      tick(0, 1, UP, 0, '0);
      check("sat_cnt", 32'(shift_cnt), 4);
      check("sat_fd",  32'(frame_done), 0);

      // SIPO capture from reset.
      sin = 4'b1101;      // si sequence 1,0,1,1 (LSB first)
      tick(1, 0, HOLD, 0, '0);
      for (int i = 0; i < 4; i++) tick(0, 1, UP, sin[i], '0);
      check("sipo_q",  32'(q), 32'h0B);
      check("sipo_fd", 32'(frame_done), 1);
      // ce=0 holds a pending pulse value, then hold mode clears it.
      tick(0, 0, UP, 1, '0);
      check("ce0_fd_hold", 32'(frame_done), 1);
      check("ce0_q_hold",  32'(q), 32'h0B);
      tick(0, 1, HOLD, 0, '0);
      tick(0, 1, HOLD, 0, '0);
      check("hold_cnt", 32'(shift_cnt), 4);
      check("hold_fd",  32'(frame_done), 0);
      check("hold_q",   32'(q), 32'h0B);

      // Shift down: load 1000, three shifts with si=0, then ce=0.
      tick(0, 1, LD, 0, 4'b1000);
      for (int i = 0; i < 3; i++) tick(0, 1, DN, 0, '0);
      check("dn_q",     32'(q), 32'h1);
      check("dn_so_dn", 32'(so_dn), 1);
      check("dn_cnt",   32'(shift_cnt), 3);
      tick(0, 0, DN, 1, '0);
      tick(0, 0, LD, 1, 4'hF);
      check("dn_ce0_q",   32'(q), 32'h1);
      check("dn_ce0_cnt", 32'(shift_cnt), 3);

      // Aborted frame: load, 2 shifts, reset, then 4 shifts.
      tick(0, 1, LD, 0, 4'b0110);
      tick(0, 1, UP, 0, '0);
      tick(0, 1, UP, 0, '0);
      tick(1, 1, UP, 0, '0);
      check("abort_cnt", 32'(shift_cnt), 0);
      for (int i = 0; i < 4; i++) begin
         tick(0, 1, UP, 1, '0);
         check("abort_fd", 32'(frame_done), (i == 3) ? 1 : 0);
      end
      check("abort_q", 32'(q), 32'hF);

`ifdef SHIFT_ROTATE_EN
      tick(0, 1, LD, 0, 4'b1001);
      rot = 1'b1;
      tick(0, 1, UP, 0, '0);
      check("rot_up_q", 32'(q), 32'h3);
      tick(0, 1, DN, 0, '0);
      tick(0, 1, DN, 0, '0);
      check("rot_dn_q", 32'(q), 32'hC);
      check("rot_cnt",  32'(shift_cnt), 3);
      rot = 1'b0;
`endif

      // Randomized phase against the model.
      for (int n = 0; n < 2000; n++) begin
         int r;
         r = int'($urandom_range(0, 15));
`ifdef SHIFT_ROTATE_EN
         rot = 1'($urandom_range(0, 1));
`endif
         tick(($urandom_range(0, 63) == 0) ? 1'b1 : 1'b0,
              ($urandom_range(0, 7) != 0) ? 1'b1 : 1'b0,
              (r < 2) ? HOLD : (r < 8) ? UP : (r < 14) ? DN : LD,
              1'($urandom_range(0, 1)),
              W'($urandom));
      end

      @(posedge CLK);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
